// File: rtl/ws2812_pkg.sv
// Shared WS2812 timing defaults and receiver state encoding.
// Used by both the transmitter and the receiver.
package ws2812_pkg;

    localparam int T_MIN_HIGH  = 8;
    localparam int T_THRESH    = 64;
    localparam int T_MAX_HIGH  = 200;
    localparam int T_RESET_GAP = 5000;
    localparam int PIXEL_BITS  = 24;

    typedef enum logic [2:0] {
        RX_SYNC,
        RX_IDLE,
        RX_HIGH,
        RX_LOW,
        RX_ERROR
    } rx_state_t;

endpackage

// File: rtl/ws2812_rx_if.sv
// Decoded pixel / frame output bundle of the WS2812 receiver.
// The receiver drives it through the master modport.
interface ws2812_rx_if #(
    parameter int PIX_W = 10
);
    logic [23:0]      o_Pixel;
    logic [PIX_W-1:0] o_Pixel_Index;
    logic             o_Valid;
    logic             o_Frame_Done;
    logic [PIX_W-1:0] o_Pixel_Count;
    logic             o_Error;
    logic             o_Busy;

    modport master (
        output o_Pixel, o_Pixel_Index, o_Valid, o_Frame_Done,
        output o_Pixel_Count, o_Error, o_Busy
    );

    modport slave (
        input o_Pixel, o_Pixel_Index, o_Valid, o_Frame_Done,
        input o_Pixel_Count, o_Error, o_Busy
    );
endinterface

// File: rtl/ws2812_rx_sync.sv
// Two-flop synchronizer for the asynchronous data pin, plus one history
// register giving single-cycle rise/fall events.
module ws2812_rx_sync (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= i_Din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;
endmodule

// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: classifies high-pulse widths into bits,
// assembles 24-bit GRB pixels and reports frame end on the latch gap.
module ws2812_rx #(
    parameter int T_MIN_HIGH  = ws2812_pkg::T_MIN_HIGH,
    parameter int T_THRESH    = ws2812_pkg::T_THRESH,
    parameter int T_MAX_HIGH  = ws2812_pkg::T_MAX_HIGH,
    parameter int T_RESET_GAP = ws2812_pkg::T_RESET_GAP,
    parameter int PIX_W       = 10
) (
    input  logic            i_Clock,
    input  logic            i_Reset,
    input  logic            i_Din,
    ws2812_rx_if.master     rx
);
    import ws2812_pkg::*;

    localparam int CW = $clog2(T_RESET_GAP + 1);
    localparam logic [CW-1:0]    C_MIN    = CW'(T_MIN_HIGH);
    localparam logic [CW-1:0]    C_THR    = CW'(T_THRESH);
    localparam logic [CW-1:0]    C_MAX    = CW'(T_MAX_HIGH);
    localparam logic [CW-1:0]    C_GAP    = CW'(T_RESET_GAP);
    localparam logic [4:0]       LAST_BIT = 5'(PIXEL_BITS - 1);
    localparam logic [PIX_W-1:0] IDX_MAX  = '1;

    logic            level;
    logic            rise;
    logic            fall;
    logic [CW-1:0]   cnt;
    logic            bit_val;
    rx_state_t       state;
    logic [4:0]      bit_cnt;
    logic [23:0]     shreg;
    logic [PIX_W-1:0] pix_idx;

    ws2812_rx_sync u_sync (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Din   (i_Din),
        .level   (level),
        .rise    (rise),
        .fall    (fall)
    );

    // Width of the current level in clocks since the last edge event.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            cnt <= '0;
        end else if (rise || fall) begin
            cnt <= '0;
        end else if (cnt != C_GAP) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_val = (cnt >= C_THR);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state            <= RX_SYNC;
            bit_cnt          <= '0;
            shreg            <= '0;
            pix_idx          <= '0;
            rx.o_Pixel       <= '0;
            rx.o_Pixel_Index <= '0;
            rx.o_Pixel_Count <= '0;
            rx.o_Valid       <= 1'b0;
            rx.o_Frame_Done  <= 1'b0;
            rx.o_Error       <= 1'b0;
            rx.o_Busy        <= 1'b1;
        end else begin
            rx.o_Valid      <= 1'b0;
            rx.o_Frame_Done <= 1'b0;
            rx.o_Error      <= 1'b0;
            case (state)
                RX_SYNC: begin
                    if (!level && cnt == C_GAP) begin
                        state     <= RX_IDLE;
                        rx.o_Busy <= 1'b0;
                    end
                end
                RX_IDLE: begin
                    if (rise) begin
                        state     <= RX_HIGH;
                        rx.o_Busy <= 1'b1;
                    end
                end
                RX_HIGH: begin
                    // A fall landing exactly on T_MAX_HIGH is still stuck-high.
                    if (cnt >= C_MAX || (fall && cnt < C_MIN)) begin
                        state      <= RX_ERROR;
                        rx.o_Error <= 1'b1;
                        bit_cnt    <= '0;
                        pix_idx    <= '0;
                    end else if (fall) begin
                        state <= RX_LOW;
                        shreg <= {shreg[22:0], bit_val};
                        if (bit_cnt == LAST_BIT) begin
                            rx.o_Valid       <= 1'b1;
                            rx.o_Pixel       <= {shreg[22:0], bit_val};
                            rx.o_Pixel_Index <= pix_idx;
                            bit_cnt          <= '0;
                            if (pix_idx != IDX_MAX) begin
                                pix_idx <= pix_idx + 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                RX_LOW: begin
                    if (rise) begin
                        state <= RX_HIGH;
                    end else if (cnt == C_GAP) begin
                        state            <= RX_IDLE;
                        rx.o_Busy        <= 1'b0;
                        rx.o_Frame_Done  <= 1'b1;
                        rx.o_Pixel_Count <= pix_idx;
                        rx.o_Error       <= (bit_cnt != '0);
                        bit_cnt          <= '0;
                        pix_idx          <= '0;
                    end
                end
                RX_ERROR: begin
                    state <= RX_SYNC;
                end
                default: begin
                    state <= RX_SYNC;
                end
            endcase
        end
    end
endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

Single-wire WS2812 stream receiver and decoder, the receive end of the LED-strip protocol our transmitter drives. It samples a GRB bitstream on one input pin and classifies each bit by its high-pulse width. It assembles 24-bit pixels MSB-first, emitting each one as a single-cycle valid strobe, and reports frame end when the line stays low for the latch gap. It is used for loopback self-test of the transmitter and for daisy-chain monitoring.

## Interface
- T_MIN_HIGH, 8: high pulses shorter than this many clocks are glitches and flag an error
- T_THRESH, 64: high width ≥ this decodes as 1, otherwise 0 (100 MHz: a 0 bit is ≈42 clocks high, a 1 bit ≈84)
- T_MAX_HIGH, 200: high width ≥ this is an error (stuck line)
- T_RESET_GAP, 5000: continuous low clocks that end a frame (50 µs at 100 MHz)
- PIX_W, 10: width of the pixel index and pixel count
- i_Clock  in  1  system clock
- i_Reset  in  1  synchronous, active-high reset
- i_Din  in  1  asynchronous WS2812 data line
- o_Pixel  out  24  last decoded pixel, GRB, G in [23:16]
- o_Pixel_Index  out  PIX_W  index of o_Pixel within the current frame, starting at 0
- o_Valid  out  1  one-cycle strobe; o_Pixel and o_Pixel_Index are valid
- o_Frame_Done  out  1  one-cycle strobe at frame end
- o_Pixel_Count  out  PIX_W  pixels in the frame just ended; valid with o_Frame_Done
- o_Error  out  1  one-cycle strobe on a glitch, over-long high, or partial pixel
- o_Busy  out  1  high whenever the FSM is not in IDLE

## Operation
- **Input conditioning:** i_Din passes through a 2-flop synchronizer plus one edge-detect register. A pin transition appears as a rise or fall event in detection cycle D, 3 clocks after the pin edge. All latencies below are relative to D.
- **Timing counter:** one counter `cnt`, $clog2(T_RESET_GAP+1) bits wide. It clears on every edge event, then increments each clock and saturates at T_RESET_GAP.
- **Bit and pixel registers:**
  - bit counter: 0..23.
  - shift register: 24 bits, shifts left, new bit in at [0].
  - pixel index: saturates at 2^PIX_W−1 and does not wrap.
- **FSM states:**
  - **SYNC:** entered on reset and from ERROR. Waits for the line to stay low for T_RESET_GAP clocks, then goes to IDLE. Any rise restarts the wait.
  - **IDLE:** on a rise, go to HIGH. The pixel index is already 0.
  - **HIGH:** on a fall, classify `cnt`:
    - < T_MIN_HIGH: error, go to ERROR.
    - ≥ T_THRESH: shift in 1.
    - otherwise: shift in 0.
    - After shifting, go to LOW.
    - If `cnt` reaches T_MAX_HIGH before a fall: error, go to ERROR.
  - **LOW:**
    - On a rise: go to HIGH.
    - When `cnt` reaches T_RESET_GAP: frame end, go to IDLE.
- **Pixel completion:** on the 24th bit, at D+1:
  - o_Valid=1.
  - o_Pixel = completed shift register value.
  - o_Pixel_Index = current index.
  - Then the index increments and the bit counter clears.
- **Frame end:** o_Frame_Done=1 with o_Pixel_Count = completed pixels. The index then clears.
  - If the bit counter ≠ 0, o_Error also pulses in the same cycle and the partial pixel is discarded.
  - A frame with zero pixels never occurs, because IDLE requires a rise.
- **ERROR entry:** o_Error pulses once; the bit counter and index clear; no o_Frame_Done is issued.
- **Backpressure:** none. The consumer must accept o_Valid in the cycle it is asserted.

## Timing
- **Reset values:**
  - o_Pixel=0, o_Pixel_Index=0, o_Pixel_Count=0.
  - o_Valid=0, o_Frame_Done=0, o_Error=0.
  - o_Busy=1, FSM in SYNC, all counters 0.
- **Strobe latencies:**
  - o_Valid asserts at D+1 after the 24th fall event.
  - o_Frame_Done asserts T_RESET_GAP clocks after the last fall event.
  - o_Error asserts at D+1 for glitch and partial-pixel errors, and in the cycle `cnt` hits T_MAX_HIGH for stuck-high.
- **Data holding:** o_Pixel, o_Pixel_Index and o_Pixel_Count hold their values between strobes.
- **Simultaneous events:** o_Valid and o_Frame_Done never coincide, since a pixel completes on a fall and a frame ends only after a gap.
- **Reset mid-operation:** i_Reset mid-frame aborts without any strobe and re-enters SYNC, so a half-seen bit is never decoded.
- **Minimum spacing:** consecutive o_Valid strobes are at least 24×(T_MIN_HIGH+1) clocks apart.

## Structure
- **Package ws2812_pkg:**
  - the timing defaults T_MIN_HIGH, T_THRESH, T_MAX_HIGH, T_RESET_GAP, shared with the transmitter.
  - the rx state enum (SYNC, IDLE, HIGH, LOW, ERROR).
  - PIXEL_BITS=24.
- **Sub-module ws2812_rx_sync:** the 2-flop synchronizer plus edge detector, with outputs level, rise and fall.

## Test plan
- **Single pixel:** after reset, hold the line low 5000 clocks, send 0xFF0000, then a 6000-clock gap → one o_Valid with o_Pixel=24'hFF0000 and o_Pixel_Index=0; later o_Frame_Done with o_Pixel_Count=1.
- **Transmitter loopback:** loopback from the transmitter with colour 0x55 (72 bits: 0x550000, 0x00FF00, 0x000011) → three o_Valid strobes with indices 0,1,2 and those pixel values; o_Pixel_Count=3; o_Error never asserts.
- **Glitch:** a 4-clock high pulse mid-pixel → o_Error pulse; no o_Valid; o_Busy stays 1 until 5000 low clocks have elapsed.
- **Partial pixel:** 30 bits then a gap → one o_Valid, then o_Frame_Done with o_Pixel_Count=1 and a simultaneous o_Error.
- **Reset mid-frame:** i_Reset asserted after bit 10 with the line high → no strobes; next frame after the gap decodes correctly from index 0.
- **Stuck high:** line held high for 300 clocks → o_Error in the cycle `cnt`=200; recovery after 5000 low clocks.
